// File: rtl/i2c_init_sequencer.sv
// i2c_init_sequencer: plays an I2C command table from a synchronous ROM into the master, then passes the host bus through
// Ports: clk, reset (async, active-high); start re-runs the table, honoured only in DONE/ERROR.
//   rom_addr/rom_data: table ROM, entry = {op[1:0], payload[31:0]} (00 END, 01 WRITE, 10 READ, 11 DELAY).
//   i2c_ctrl_data/i2c_wr_ctrl/i2c_read/i2c_status: master control and status word.
//   host_ctrl_data/host_wr_ctrl/host_read/host_status: host bus, routed to the master once the table is finished.
//   seq_busy/seq_done/seq_err/err_code/err_index: progress and failure report; rd_data/rd_valid: last READ byte.
module i2c_init_sequencer #(
  parameter int ADDR_W = 6,
  parameter int MAX_RETRY = 3,
  parameter int BUSY_TIMEOUT = 16,
  parameter bit AUTO_START = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [33:0]       rom_data,
  output logic [31:0]       i2c_ctrl_data,
  output logic              i2c_wr_ctrl,
  output logic              i2c_read,
  input  logic [31:0]       i2c_status,
  input  logic [31:0]       host_ctrl_data,
  input  logic              host_wr_ctrl,
  input  logic              host_read,
  output logic [31:0]       host_status,
  output logic              seq_busy,
  output logic              seq_done,
  output logic              seq_err,
  output logic [1:0]        err_code,
  output logic [ADDR_W-1:0] err_index,
  output logic [7:0]        rd_data,
  output logic              rd_valid
);
  localparam logic [3:0] S_WAIT_INIT = 4'd0, S_FETCH = 4'd1, S_DECODE = 4'd2, S_ISSUE = 4'd3, S_WAIT_BUSY = 4'd4;
  localparam logic [3:0] S_WAIT_IDLE = 4'd5, S_CHECK = 4'd6, S_DELAY = 4'd7, S_DONE = 4'd8, S_ERROR = 4'd9;
  localparam logic [1:0] OP_END = 2'b00, OP_READ = 2'b10, OP_DELAY = 2'b11;
  localparam logic [ADDR_W-1:0] PC_LAST = '1;
  localparam logic [ADDR_W-1:0] PC_ONE = 1;
  localparam logic [7:0] RETRY_MAX = 8'(MAX_RETRY);
  localparam logic [15:0] TMO_LAST = 16'(BUSY_TIMEOUT - 1);
  logic [3:0] state;
  logic [ADDR_W-1:0] pc;
  logic [31:0] ctrl_q;
  logic read_q;
  logic [23:0] delay_cnt;
  logic [15:0] timer;
  logic [7:0] retry_cnt;
  logic [1:0] op;
  logic busy, nack, last, step;
  assign op = rom_data[33:32];
  assign busy = i2c_status[31];
  assign nack = i2c_status[30] | i2c_status[29];
  assign last = pc == PC_LAST;
  // step: the current entry has completed; advance to the next one, or finish once the last ROM slot has run
  assign step = (state == S_CHECK && !nack) ||
                (state == S_DELAY && delay_cnt <= 24'd1) ||
                (state == S_DECODE && op == OP_DELAY && rom_data[23:0] == 24'd0);
  assign seq_busy = state != S_DONE && state != S_ERROR;
  assign rom_addr = pc;
  assign i2c_ctrl_data = seq_busy ? ctrl_q : host_ctrl_data;
  assign i2c_wr_ctrl = seq_busy ? state == S_ISSUE : host_wr_ctrl;
  assign i2c_read = seq_busy ? read_q : host_read;
  assign host_status = {i2c_status[31] | seq_busy, i2c_status[30:0]};
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state <= AUTO_START ? S_WAIT_INIT : S_DONE;
      pc <= '0;
      ctrl_q <= '0;
      read_q <= 1'b0;
      delay_cnt <= '0;
      timer <= '0;
      retry_cnt <= '0;
      seq_done <= 1'b0;
      seq_err <= 1'b0;
      err_code <= 2'b00;
      err_index <= '0;
      rd_data <= '0;
      rd_valid <= 1'b0;
    end else begin
      rd_valid <= 1'b0;
      case (state)
        S_WAIT_INIT: if (!i2c_status[26] && !busy) state <= S_FETCH;
        S_FETCH: state <= S_DECODE;
        S_DECODE: begin
          retry_cnt <= '0;
          delay_cnt <= rom_data[23:0];
          if (op == OP_END) begin state <= S_DONE; seq_done <= 1'b1; end
          else if (op == OP_DELAY) state <= S_DELAY;
          else begin ctrl_q <= rom_data[31:0]; read_q <= op == OP_READ; state <= S_ISSUE; end
        end
        S_ISSUE: begin timer <= '0; state <= S_WAIT_BUSY; end
        S_WAIT_BUSY:
          if (busy) state <= S_WAIT_IDLE;
          else if (timer == TMO_LAST) begin state <= S_ERROR; seq_err <= 1'b1; err_code <= 2'b10; err_index <= pc; end
          else timer <= timer + 16'd1;
        S_WAIT_IDLE: if (!busy) state <= S_CHECK;
        S_CHECK:
          if (nack && retry_cnt < RETRY_MAX) begin retry_cnt <= retry_cnt + 8'd1; state <= S_ISSUE; end
          else if (nack) begin state <= S_ERROR; seq_err <= 1'b1; err_code <= 2'b01; err_index <= pc; end
          else if (read_q) begin rd_data <= i2c_status[7:0]; rd_valid <= 1'b1; end
        S_DELAY: delay_cnt <= delay_cnt - 24'd1;
        default:
          if (start) begin state <= S_WAIT_INIT; pc <= '0; seq_done <= 1'b0; seq_err <= 1'b0; err_code <= 2'b00; end
      endcase
      if (step) begin
        state <= last ? S_DONE : S_FETCH;
        seq_done <= last;
        if (!last) pc <= pc + PC_ONE;
      end
    end
endmodule

// File: tb/tb_i2c_init_sequencer.sv
// tb_i2c_init_sequencer: randomized and directed checks of i2c_init_sequencer against a table-level reference model
module tb_i2c_init_sequencer;
  localparam int AW = 6, RETRY = 3, TMO = 16;
  localparam logic [1:0] OP_E = 2'b00, OP_W = 2'b01, OP_R = 2'b10, OP_D = 2'b11;
  localparam logic [59:0] RST_VEC = {6'd0, 1'b0, 1'b0, 32'd0, 1'b1, 1'b0, 1'b0, 2'd0, 6'd0, 8'd0, 1'b0};
  logic clk = 1'b0, reset = 1'b0, start = 1'b0;
  logic [AW-1:0] rom_addr, err_index;
  logic [33:0] rom_data = '0;
  logic [31:0] i2c_ctrl_data, i2c_status, host_ctrl_data = '0, host_status;
  logic i2c_wr_ctrl, i2c_read, host_wr_ctrl = 1'b0, host_read = 1'b0;
  logic seq_busy, seq_done, seq_err, rd_valid;
  logic [1:0] err_code;
  logic [7:0] rd_data;
  logic [33:0] rom [64];
  logic slv_busy = 1'b0, slv_nack = 1'b0, slv_dead = 1'b0, slv_init = 1'b0;
  int slv_cnt = 0, slv_lat = 2;
  logic [7:0] slv_rd = '0;
  int total = 0, bad = 0;
  logic [31:0] got_word[$], exp_word[$];
  logic [AW-1:0] got_addr[$];
  int got_t[$];
  logic got_sel[$];
  logic [7:0] got_rd[$], exp_rd[$];
  int hold_bad, overlap;
  logic exp_done, exp_err;
  logic [1:0] exp_code;
  logic [AW-1:0] exp_idx;

  i2c_init_sequencer #(.ADDR_W(AW), .MAX_RETRY(RETRY), .BUSY_TIMEOUT(TMO), .AUTO_START(1'b1)) dut (
    .clk(clk), .reset(reset), .start(start), .rom_addr(rom_addr), .rom_data(rom_data),
    .i2c_ctrl_data(i2c_ctrl_data), .i2c_wr_ctrl(i2c_wr_ctrl), .i2c_read(i2c_read), .i2c_status(i2c_status),
    .host_ctrl_data(host_ctrl_data), .host_wr_ctrl(host_wr_ctrl), .host_read(host_read), .host_status(host_status),
    .seq_busy(seq_busy), .seq_done(seq_done), .seq_err(seq_err), .err_code(err_code), .err_index(err_index),
    .rd_data(rd_data), .rd_valid(rd_valid));

  always #5 clk = ~clk;
  always @(posedge clk) rom_data <= rom[rom_addr];

  // master stub: a write strobe makes it busy for slv_lat cycles; NACK bits and read byte are fixed per run
  always @(posedge clk)
    if (i2c_wr_ctrl && !slv_dead) begin slv_busy <= 1'b1; slv_cnt <= slv_lat; end
    else if (slv_busy) begin slv_cnt <= slv_cnt - 1; if (slv_cnt == 1) slv_busy <= 1'b0; end
  assign i2c_status = {slv_busy, slv_nack, 3'b000, slv_init, 18'd0, slv_rd};

  function automatic logic [59:0] outs();
    return {rom_addr, i2c_wr_ctrl, i2c_read, i2c_ctrl_data, seq_busy, seq_done, seq_err, err_code, err_index, rd_data, rd_valid};
  endfunction

  function automatic logic [33:0] ent(input logic [1:0] op, input logic [31:0] p);
    return {op, p};
  endfunction

  task automatic tick(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic clear_rom();
    for (int i = 0; i < 64; i++) rom[i] = '0;
  endtask

  task automatic run_reset();
    reset = 1'b1; tick(1); reset = 1'b0;
  endtask

  // records every sequencer-issued transfer and READ result until the run finishes or the budget expires
  task automatic collect(input int bound, output bit to, output int end_t);
    logic [31:0] xw;
    logic xr;
    bit have;
    xw = '0; xr = 1'b0; have = 0;
    got_word.delete(); got_addr.delete(); got_t.delete(); got_sel.delete(); got_rd.delete();
    hold_bad = 0; overlap = 0; to = 1; end_t = -1;
    for (int c = 0; c < bound; c++) begin
      if (seq_busy && i2c_wr_ctrl) begin
        got_word.push_back(i2c_ctrl_data); got_addr.push_back(rom_addr); got_t.push_back(c); got_sel.push_back(i2c_read);
        if (slv_busy) overlap++;
        xw = i2c_ctrl_data; xr = i2c_read; have = 1;
      end
      if (have && seq_busy && slv_busy && (i2c_ctrl_data !== xw || i2c_read !== xr)) hold_bad++;
      if (rd_valid) got_rd.push_back(rd_data);
      if (seq_done || seq_err) begin to = 0; end_t = c; break; end
      tick(1);
    end
  endtask

  // walks the table entry by entry: every WRITE/READ costs one transfer, or 1+MAX_RETRY when the slave NACKs
  task automatic model_run();
    logic [1:0] op;
    exp_word.delete(); exp_rd.delete();
    exp_done = 1'b1; exp_err = 1'b0; exp_code = 2'b00; exp_idx = '0;
    for (int p = 0; p < 64; p++) begin
      op = rom[p][33:32];
      if (op == OP_E) break;
      if (op == OP_D) continue;
      for (int a = 0; a < (slv_nack ? RETRY + 1 : 1); a++) exp_word.push_back(rom[p][31:0]);
      if (slv_nack) begin exp_done = 1'b0; exp_err = 1'b1; exp_code = 2'b01; exp_idx = AW'(p); break; end
      if (op == OP_R) exp_rd.push_back(slv_rd);
    end
  endtask

  task automatic test_reset();
    int viol;
    bit to;
    int et;
    clear_rom(); slv_init = 1'b1; slv_nack = 1'b0; slv_dead = 1'b0;
    reset = 1'b1; #1;
    total++; if (outs() !== RST_VEC) begin bad++; $display("FAIL reset_values got=%h want=%h", outs(), RST_VEC); end
    tick(2); reset = 1'b0;
    viol = 0;
    for (int i = 0; i < 8; i++) begin tick(1); if (i2c_wr_ctrl || !seq_busy || seq_done) viol++; end
    total++; if (viol != 0) begin bad++; $display("FAIL wait_init_hold got=%0d violations want=0", viol); end
    slv_init = 1'b0;
    collect(50, to, et);
    total++; if (to || seq_done !== 1'b1) begin bad++; $display("FAIL empty_table_done got=%b timeout=%0b want=1", seq_done, to); end
    total++; if (got_word.size() != 0) begin bad++; $display("FAIL empty_table_writes got=%0d want=0", got_word.size()); end
  endtask

  task automatic test_write_table();
    bit to;
    int et;
    clear_rom(); slv_lat = 3;
    rom[0] = ent(OP_W, 32'h00421005); rom[1] = ent(OP_W, 32'h00422000);
    run_reset(); collect(500, to, et);
    total++; if (to) begin bad++; $display("FAIL write_table_timeout got=timeout want=finish"); end
    total++; if (got_word.size() != 2) begin bad++; $display("FAIL write_count got=%0d want=2", got_word.size()); end
    total++; if (got_word[0] !== 32'h00421005 || got_word[1] !== 32'h00422000) begin
      bad++; $display("FAIL write_words got=%h,%h want=00421005,00422000", got_word[0], got_word[1]); end
    total++; if (got_addr[0] !== 6'd0 || got_addr[1] !== 6'd1 || rom_addr !== 6'd2) begin
      bad++; $display("FAIL rom_addr_seq got=%0d,%0d,%0d want=0,1,2", got_addr[0], got_addr[1], rom_addr); end
    total++; if (seq_done !== 1'b1 || seq_err !== 1'b0 || seq_busy !== 1'b0) begin
      bad++; $display("FAIL write_flags got=done%b err%b busy%b want=done1 err0 busy0", seq_done, seq_err, seq_busy); end
  endtask

  task automatic test_read();
    bit to;
    int et;
    clear_rom(); slv_lat = 4; slv_rd = 8'hA5;
    rom[0] = ent(OP_R, 32'h00420300);
    run_reset(); collect(500, to, et);
    total++; if (to || got_rd.size() != 1) begin bad++; $display("FAIL read_pulses got=%0d timeout=%0b want=1", got_rd.size(), to); end
    total++; if (got_rd[0] !== 8'hA5 || rd_data !== 8'hA5) begin bad++; $display("FAIL read_data got=%h/%h want=a5", got_rd[0], rd_data); end
    total++; if (got_sel[0] !== 1'b1 || hold_bad != 0) begin
      bad++; $display("FAIL read_select_held got=sel%b unstable%0d want=sel1 unstable0", got_sel[0], hold_bad); end
  endtask

  task automatic test_nack();
    bit to;
    int et, m;
    clear_rom(); slv_lat = 2; slv_nack = 1'b1;
    rom[0] = ent(OP_W, 32'h0042AA55); rom[1] = ent(OP_W, 32'h00421234);
    run_reset(); collect(1000, to, et);
    m = 0;
    foreach (got_word[i]) if (got_word[i] !== 32'h0042AA55) m++;
    total++; if (got_word.size() != RETRY + 1 || m != 0) begin
      bad++; $display("FAIL nack_attempts got=%0d (%0d wrong) want=%0d", got_word.size(), m, RETRY + 1); end
    total++; if (to || seq_err !== 1'b1 || seq_done !== 1'b0 || err_code !== 2'b01 || err_index !== 6'd0) begin
      bad++; $display("FAIL nack_error got=err%b done%b code%b idx%0d want=err1 done0 code01 idx0", seq_err, seq_done, err_code, err_index); end
    total++; if (rom_addr !== 6'd0) begin bad++; $display("FAIL nack_no_fetch got=%0d want=0", rom_addr); end
    slv_nack = 1'b0;
  endtask

  task automatic test_delay();
    bit to;
    int et, g0, n;
    int ns[3];
    clear_rom(); slv_lat = 3;
    rom[0] = ent(OP_W, 32'h00420001); rom[1] = ent(OP_W, 32'h00420002);
    run_reset(); collect(500, to, et);
    g0 = got_t[1] - got_t[0];
    ns[0] = 0; ns[1] = 100; ns[2] = int'($urandom_range(1, 40));
    foreach (ns[k]) begin
      n = ns[k];
      clear_rom();
      rom[0] = ent(OP_W, 32'h00420001); rom[1] = ent(OP_D, 32'(n)); rom[2] = ent(OP_W, 32'h00420002);
      run_reset(); collect(1000, to, et);
      total++; if (to || got_t.size() != 2 || got_t[1] - got_t[0] != g0 + 2 + n) begin
        bad++; $display("FAIL delay_%0d_gap got=%0d want=%0d", n, got_t[1] - got_t[0], g0 + 2 + n); end
    end
  endtask

  task automatic test_timeout();
    bit to;
    int et;
    clear_rom(); slv_lat = 2; slv_dead = 1'b1;
    rom[0] = ent(OP_D, 32'd3); rom[1] = ent(OP_W, 32'h00425A5A);
    run_reset(); collect(500, to, et);
    total++; if (to || seq_err !== 1'b1 || err_code !== 2'b10 || err_index !== 6'd1) begin
      bad++; $display("FAIL timeout_error got=err%b code%b idx%0d want=err1 code10 idx1", seq_err, err_code, err_index); end
    total++; if (got_t.size() != 1 || et - got_t[0] != TMO + 1) begin
      bad++; $display("FAIL timeout_latency got=%0d want=%0d", et - got_t[0], TMO + 1); end
    slv_dead = 1'b0;
    start = 1'b1; tick(1); start = 1'b0;
    total++; if (seq_err !== 1'b0 || err_code !== 2'b00 || seq_busy !== 1'b1 || rom_addr !== 6'd0) begin
      bad++; $display("FAIL restart_clear got=err%b code%b busy%b addr%0d want=err0 code00 busy1 addr0", seq_err, err_code, seq_busy, rom_addr); end
    collect(500, to, et);
    total++; if (to || seq_done !== 1'b1 || got_word.size() != 1 || got_addr[0] !== 6'd1) begin
      bad++; $display("FAIL restart_run got=done%b writes%0d want=done1 writes1", seq_done, got_word.size()); end
  endtask

  task automatic test_host();
    bit to;
    int et;
    clear_rom(); slv_lat = 3; slv_rd = 8'h3C;
    rom[0] = ent(OP_D, 32'd50); rom[1] = ent(OP_E, 32'd0);
    run_reset(); tick(10);
    host_ctrl_data = 32'h00430011; host_wr_ctrl = 1'b1; #1;
    total++; if (i2c_wr_ctrl !== 1'b0 || i2c_ctrl_data !== 32'd0 || host_status[31] !== 1'b1) begin
      bad++; $display("FAIL host_blocked got=wr%b data%h st31%b want=wr0 data0 st31=1", i2c_wr_ctrl, i2c_ctrl_data, host_status[31]); end
    tick(1); host_wr_ctrl = 1'b0;
    total++; if (slv_busy !== 1'b0) begin bad++; $display("FAIL host_not_queued got=%b want=0", slv_busy); end
    rom[0] = ent(OP_R, 32'h00420300);
    run_reset(); collect(500, to, et);
    host_ctrl_data = 32'h00430011; host_wr_ctrl = 1'b1; host_read = 1'b0; #1;
    total++; if (i2c_wr_ctrl !== 1'b1 || i2c_ctrl_data !== 32'h00430011 || host_status !== i2c_status) begin
      bad++; $display("FAIL host_forward got=wr%b data%h st%h want=wr1 data00430011 st%h", i2c_wr_ctrl, i2c_ctrl_data, host_status, i2c_status); end
    tick(1); host_wr_ctrl = 1'b0; host_ctrl_data = '0;
    total++; if (slv_busy !== 1'b1 || host_status !== i2c_status) begin
      bad++; $display("FAIL host_status_pass got=%h want=%h", host_status, i2c_status); end
    reset = 1'b1; #1;
    total++; if (outs() !== RST_VEC) begin bad++; $display("FAIL midxfer_reset got=%h want=%h", outs(), RST_VEC); end
    tick(2);
    total++; if (i2c_wr_ctrl !== 1'b0) begin bad++; $display("FAIL reset_no_strobe got=%b want=0", i2c_wr_ctrl); end
    reset = 1'b0;
    collect(500, to, et);
  endtask

  task automatic test_back_to_back();
    bit to;
    int et;
    clear_rom(); slv_lat = 5;
    rom[0] = ent(OP_W, 32'h00421111);
    start = 1'b1; host_wr_ctrl = 1'b1; host_ctrl_data = 32'h00437777; #1;
    total++; if (i2c_wr_ctrl !== 1'b1 || i2c_ctrl_data !== 32'h00437777) begin
      bad++; $display("FAIL start_host_same got=wr%b data%h want=wr1 data00437777", i2c_wr_ctrl, i2c_ctrl_data); end
    tick(1); start = 1'b0; host_wr_ctrl = 1'b0; host_ctrl_data = '0;
    collect(500, to, et);
    total++; if (to || overlap != 0 || got_word.size() != 1 || got_word[0] !== 32'h00421111) begin
      bad++; $display("FAIL start_waits_host got=overlap%0d writes%0d want=overlap0 writes1", overlap, got_word.size()); end
  endtask

  task automatic test_random();
    bit to;
    int et, n, m;
    logic [1:0] op;
    for (int it = 0; it < 8; it++) begin
      clear_rom();
      slv_lat = int'($urandom_range(1, 4)); slv_rd = 8'($urandom);
      slv_nack = (it != 0) && ($urandom_range(0, 3) == 0);
      n = (it == 0) ? 64 : int'($urandom_range(1, 6));
      for (int i = 0; i < n; i++) begin
        op = 2'($urandom_range(1, 3));
        rom[i] = {op, (op == OP_D) ? 32'($urandom_range(0, 5)) : 32'($urandom)};
      end
      model_run();
      run_reset(); collect(20000, to, et);
      m = 0;
      foreach (exp_word[i]) if (i >= got_word.size() || got_word[i] !== exp_word[i]) m++;
      total++; if (to || got_word.size() != exp_word.size() || m != 0) begin
        bad++; $display("FAIL rand%0d_writes got=%0d (%0d wrong) want=%0d", it, got_word.size(), m, exp_word.size()); end
      m = 0;
      foreach (exp_rd[i]) if (i >= got_rd.size() || got_rd[i] !== exp_rd[i]) m++;
      total++; if (got_rd.size() != exp_rd.size() || m != 0 || hold_bad != 0) begin
        bad++; $display("FAIL rand%0d_reads got=%0d (%0d wrong, %0d unstable) want=%0d", it, got_rd.size(), m, hold_bad, exp_rd.size()); end
      total++; if (seq_done !== exp_done || seq_err !== exp_err || err_code !== exp_code || (exp_err && err_index !== exp_idx)) begin
        bad++; $display("FAIL rand%0d_status got=done%b err%b code%b idx%0d want=done%b err%b code%b idx%0d",
          it, seq_done, seq_err, err_code, err_index, exp_done, exp_err, exp_code, exp_idx); end
      if (it == 0) begin
        total++; if (rom_addr !== 6'd63) begin bad++; $display("FAIL wrap_addr got=%0d want=63", rom_addr); end
      end
    end
    slv_nack = 1'b0;
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog got=running want=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    clear_rom();
    tick(1);
    test_reset();
    test_write_table();
    test_read();
    test_nack();
    test_delay();
    test_timeout();
    test_host();
    test_back_to_back();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/i2c_init_sequencer.md
Name: i2c_init_sequencer

Overview:
Sequencer in front of the I2C master. After reset (or on `start`), it plays a table of I2C commands from a synchronous ROM: register writes, register reads and fixed delays. It drives the master's control interface, watches its status word, retries NACKed transfers and reports errors. Once the table finishes, it passes the host bus interface straight through to the master.

Parameters:
ADDR_W, 6, ROM address width; table depth 2^ADDR_W entries
MAX_RETRY, 3, extra attempts per WRITE/READ entry after a NACK (0 = no retry)
BUSY_TIMEOUT, 16, cycles allowed from issue until master busy (status[31]) is seen high
AUTO_START, 1, 1 = run the table automatically after reset

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high
start  in  1  one-cycle pulse; re-runs the table from entry 0 (only in DONE/ERROR)
rom_addr  out  ADDR_W  table address, registered
rom_data  in  34  entry; [33:32] op (00 END, 01 WRITE, 10 READ, 11 DELAY), [31:0] payload
i2c_ctrl_data  out  32  to master control-register data
i2c_wr_ctrl  out  1  to master write strobe
i2c_read  out  1  to master read select
i2c_status  in  32  from master; [31] busy, [30] addr NACK, [29] data NACK, [26] initializing, [7:0] read data
host_ctrl_data  in  32  host control word
host_wr_ctrl  in  1  host write strobe
host_read  in  1  host read select
host_status  out  32  status seen by host
seq_busy  out  1  table in progress
seq_done  out  1  table finished without error (sticky until start/reset)
seq_err  out  1  table aborted (sticky until start/reset)
err_code  out  2  01 NACK retries exhausted, 10 busy timeout, 00 none
err_index  out  ADDR_W  entry index that failed
rd_data  out  8  data from the most recent READ entry
rd_valid  out  1  one-cycle pulse when rd_data updates

Behaviour:
- Reset values: rom_addr=0, i2c_wr_ctrl=0, i2c_read=0, i2c_ctrl_data=0, seq_busy=AUTO_START, seq_done=0, seq_err=0, err_code=0, err_index=0, rd_data=0, rd_valid=0. State is WAIT_INIT if AUTO_START, otherwise DONE with seq_done=0.
- Reset mid-transfer aborts at once; no further wr_ctrl is issued.
- States:
  - WAIT_INIT: stay until i2c_status[26]=0 and [31]=0.
  - FETCH: rom_addr=pc.
  - DECODE: rom_data is valid one cycle after FETCH.
  - ISSUE
  - WAIT_BUSY
  - WAIT_IDLE
  - CHECK
  - DELAY
  - DONE
  - ERROR
- DECODE dispatch:
  - END: go to DONE with seq_done=1.
  - DELAY: load counter = payload[23:0]. Stay in DELAY while counter != 0, decrementing each cycle. N=0 falls through in 1 cycle.
  - WRITE/READ: latch payload into i2c_ctrl_data and set i2c_read = (op==READ); go to ISSUE. retry_cnt is cleared on each new entry.
- ISSUE: i2c_wr_ctrl=1 for exactly one cycle, then WAIT_BUSY.
- i2c_ctrl_data and i2c_read are held stable from ISSUE until CHECK.
- WAIT_BUSY: wait for i2c_status[31]=1, then WAIT_IDLE. A timer counts BUSY_TIMEOUT cycles; on expiry go to ERROR with err_code=10.
- WAIT_IDLE: wait for i2c_status[31]=0, then CHECK. No timeout here; the master bounds the transfer.
- CHECK:
  - NACK = status[30] | status[29].
  - On NACK with retry_cnt < MAX_RETRY: retry_cnt++, go to ISSUE.
  - On NACK with retries exhausted: go to ERROR with err_code=01, err_index=pc.
  - On ACK: for READ, rd_data=status[7:0] and rd_valid=1 for one cycle. Then pc++ and go to FETCH.
- pc wrap: after executing entry 2^ADDR_W-1 without an END, go to DONE as if END were read.
- DONE/ERROR:
  - seq_busy=0.
  - start clears seq_done, seq_err, err_code and pc, sets seq_busy=1 and goes to WAIT_INIT. start in any other state is ignored.
- Host mux (combinational):
  - While seq_busy=0: i2c_ctrl_data/i2c_wr_ctrl/i2c_read = host_* and host_status = i2c_status.
  - While seq_busy=1: host_wr_ctrl is discarded (not queued) and host_status = i2c_status with bit 31 forced to 1.
- If start and host_wr_ctrl arrive in the same cycle: the host write passes through (seq_busy is still 0); the sequencer then waits in WAIT_INIT for that transfer to finish.

Test Plan:
- Table [WRITE 0x00421005, WRITE 0x00422000, END] with ACKing slave model -> exactly two wr_ctrl pulses, data matches each word, seq_done=1, seq_err=0, rom_addr sequence 0,1,2.
- Entry 0 READ 0x00420300, slave returns 0xA5 -> rd_valid pulses once, rd_data=0xA5, i2c_read held 1 through the whole transfer.
- Slave NACKs address always, MAX_RETRY=3 -> 4 wr_ctrl pulses for entry 0, then seq_err=1, err_code=01, err_index=0, no fetch of entry 1.
- DELAY 100 between two WRITEs -> exactly 100 cycles in DELAY plus 1-cycle DECODE before second ISSUE; DELAY 0 -> no stall.
- Master stub never asserts busy -> ERROR after 16 cycles with err_code=10; start then re-runs from pc=0 and clears flags.
- During sequencing, host_wr_ctrl pulse -> not forwarded, host_status[31]=1; after DONE, host write 0x00430011 is forwarded in the same cycle and reset asserted mid-transfer returns all outputs to reset values.
